// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM state encoding
// and the default test pattern.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] PAT_101 = 3'b101;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable left-shift register with zero fill; the MSB is the serial tap.
// Load takes priority over shift so a pattern can be reloaded on its last bit.
module seq_shift_reg #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_val,
    output logic         msb
);

    logic [W-1:0] q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

    assign msb = q[W-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first repeat_n times,
// optionally separated by single 0 gap bits. Outputs are decoded from state only.
module seq_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             gap_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(PAT_W - 1);

    state_t           state, state_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [CNT_W-1:0] reps_left, reps_left_n;
    logic [PAT_W-1:0] pat_q, pat_n;
    logic             gap_q, gap_n;
    logic             sr_load, sr_shift, sr_msb;
    logic [PAT_W-1:0] sr_load_val;

    seq_shift_reg #(.W(PAT_W)) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .load     (sr_load),
        .shift    (sr_shift),
        .load_val (sr_load_val),
        .msb      (sr_msb)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            reps_left <= '0;
            pat_q     <= '0;
            gap_q     <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            reps_left <= reps_left_n;
            pat_q     <= pat_n;
            gap_q     <= gap_n;
        end
    end

    // The repeat counter is decremented on each pattern's last bit, so a
    // full-scale repeat_n finishes at 1 and never wraps.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        reps_left_n = reps_left;
        pat_n       = pat_q;
        gap_n       = gap_q;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_load_val = pat_q;

        case (state)
            IDLE: begin
                if (start) begin
                    if (repeat_n != '0) begin
                        pat_n       = pattern;
                        gap_n       = gap_en;
                        reps_left_n = repeat_n;
                        bit_cnt_n   = LAST_IDX;
                        sr_load     = 1'b1;
                        sr_load_val = pattern;
                        state_n     = SHIFT;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            SHIFT: begin
                sr_shift = 1'b1;
                if (bit_cnt == '0) begin
                    reps_left_n = reps_left - CNT_W'(1);
                    if (reps_left == CNT_W'(1)) begin
                        state_n = DONE;
                    end else if (gap_q) begin
                        state_n = GAP;
                    end else begin
                        sr_load   = 1'b1;
                        bit_cnt_n = LAST_IDX;
                    end
                end else begin
                    bit_cnt_n = bit_cnt - BW'(1);
                end
            end
            GAP: begin
                sr_load   = 1'b1;
                bit_cnt_n = LAST_IDX;
                state_n   = SHIFT;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign dout       = (state == SHIFT) ? sr_msb : 1'b0;
    assign dout_valid = (state == SHIFT) || (state == GAP);
    assign busy       = (state == SHIFT) || (state == GAP);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: each burst is compared cycle by cycle against
// an expected output stream built from the pattern/repeat/gap rules.
module tb_seq_gen;

    localparam int PAT_W = 3;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic             gap_en;
    logic             dout, dout_valid, busy, done;

    int checks = 0;
    int passes = 0;

    // Expected per-cycle outputs packed as {dout_valid, dout, busy, done}.
    logic [3:0] expq[$];

    always #5 clk = ~clk;

    seq_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pattern    (pattern),
        .repeat_n   (repeat_n),
        .gap_en     (gap_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic buildModel(input logic [PAT_W-1:0] pat, input int n, input bit gap);
        expq.delete();
        for (int r = 0; r < n; r++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                expq.push_back({1'b1, pat[b], 1'b1, 1'b0});
            if (gap && (r < n - 1))
                expq.push_back(4'b1010);
        end
        expq.push_back(4'b0001);
        expq.push_back(4'b0000);
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {dout_valid, dout, busy, done};
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed valid/dout/busy/done=%b expected %b at %0t",
                    tag, obs, exp, $time);
    endtask

    // Called at posedge+1 with the DUT idle; start is sampled at the next edge.
    task automatic applyStimulus(input string tag, input logic [PAT_W-1:0] pat, input int n,
                                 input bit gap, input int glitch_at, input int reset_at);
        buildModel(pat, n, gap);
        pattern  = pat;
        repeat_n = CNT_W'(n);
        gap_en   = gap;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < expq.size(); i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            checkOutput($sformatf("%s[%0d]", tag, i), expq[i]);
            pattern  = PAT_W'($urandom);
            repeat_n = CNT_W'($urandom);
            gap_en   = 1'($urandom);
            start    = (i == glitch_at);
            if (i == reset_at) begin
                start = 1'b0;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                checkOutput({tag, "_after_reset"}, 4'b0000);
                return;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        pattern  = '0;
        repeat_n = '0;
        gap_en   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 4'b0000);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("idle", 4'b0000);

        applyStimulus("single",   seq_pkg::PAT_101, 1, 1'b0, -1, -1);
        applyStimulus("rep3",     seq_pkg::PAT_101, 3, 1'b0, -1, -1);
        applyStimulus("gap2",     seq_pkg::PAT_101, 2, 1'b1, -1, -1);
        applyStimulus("glitch",   seq_pkg::PAT_101, 2, 1'b0,  1, -1);
        applyStimulus("zero",     seq_pkg::PAT_101, 0, 1'b0, -1, -1);
        applyStimulus("midreset", seq_pkg::PAT_101, 3, 1'b0, -1,  4);
        repeat (2) begin
            @(posedge clk); #1;
            checkOutput("post_reset_idle", 4'b0000);
        end
        applyStimulus("fresh",    seq_pkg::PAT_101, 3, 1'b0, -1, -1);
        applyStimulus("max_rep",  3'b011, (1 << CNT_W) - 1, 1'b1, -1, -1);

        for (int k = 0; k < 12; k++) begin
            applyStimulus($sformatf("rand%0d", k), PAT_W'($urandom),
                          int'($urandom_range(0, 5)), 1'($urandom),
                          int'($urandom_range(0, 1)) == 1 ? 1 : -1, -1);
        end

        // start held high: bursts repeat with one idle cycle between them.
        buildModel(3'b110, 1, 1'b0);
        pattern  = 3'b110;
        repeat_n = CNT_W'(1);
        gap_en   = 1'b0;
        start    = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < expq.size(); i++) begin
                @(posedge clk); #1;
                checkOutput($sformatf("held%0d[%0d]", r, i), expq[i]);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        checkOutput("held_release", 4'b0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
